// File: rtl/mnist_pkg.sv
// Shared types and constants for the MNIST inference sequencer slice.
package mnist_pkg;

  localparam int          LABEL_W       = 4;
  localparam int          IDX_W         = 6;
  localparam int          DEFAULT_PIX_W = 784;
  localparam logic [7:0]  ASCII_ZERO    = 8'h30;

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1_ISSUE,
    S_L1_WAIT,
    S_L2_ISSUE,
    S_L2_WAIT,
    S_REPORT,
    S_TX_WAIT
  } seq_state_t;

endpackage

// File: rtl/inference_sequencer_if.sv
// Neuron-engine request/response and UART transmit handshake between the
// sequencer (master) and its engine/transmitter peers (slave).
interface inference_sequencer_if #(
  parameter int PIX_W   = 784,
  parameter int SCORE_W = 16
);
  import mnist_pkg::*;

  logic                      eng_start;
  logic                      eng_layer;
  logic [IDX_W-1:0]          eng_index;
  logic [PIX_W-1:0]          eng_pixels;
  logic                      eng_done;
  logic signed [SCORE_W-1:0] eng_score;
  logic                      tx_start;
  logic [7:0]                tx_data;
  logic                      tx_busy;

  modport master (
    output eng_start, eng_layer, eng_index, eng_pixels, tx_start, tx_data,
    input  eng_done, eng_score, tx_busy
  );

  modport slave (
    input  eng_start, eng_layer, eng_index, eng_pixels, tx_start, tx_data,
    output eng_done, eng_score, tx_busy
  );

endinterface

// File: rtl/inference_sequencer_argmax_tracker.sv
// Running signed argmax over output-neuron scores; ties keep the lowest index
// because only a strictly greater score replaces the current best.
module argmax_tracker
  import mnist_pkg::*;
#(
  parameter int SCORE_W = 16
) (
  input  logic                      clk,
  input  logic                      reset_b,
  input  logic                      init,
  input  logic                      update,
  input  logic signed [SCORE_W-1:0] score,
  input  logic [LABEL_W-1:0]        index,
  output logic [LABEL_W-1:0]        best_idx
);

  logic signed [SCORE_W-1:0] best_score_q;
  logic [LABEL_W-1:0]        best_idx_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      best_score_q <= '0;
      best_idx_q   <= '0;
    end else if (init || (update && (score > best_score_q))) begin
      best_score_q <= score;
      best_idx_q   <= index;
    end
  end

  assign best_idx = best_idx_q;

endmodule

// File: rtl/inference_sequencer.sv
// Sequences one inference: all hidden neurons, then all output neurons on the
// shared engine, then reports the argmax and sends it as an ASCII digit.
module inference_sequencer
  import mnist_pkg::*;
#(
  parameter int N_HIDDEN = 32,
  parameter int N_OUT    = 10,
  parameter int SCORE_W  = 16,
  parameter int PIX_W    = DEFAULT_PIX_W
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 frame_valid,
  input  logic [LABEL_W-1:0]   frame_label,
  input  logic [PIX_W-1:0]     frame_pixels,
  inference_sequencer_if.master bus,
  output logic                 pred_valid,
  output logic [LABEL_W-1:0]   pred_out,
  output logic [15:0]          frame_cnt,
  output logic [15:0]          correct_cnt,
  output logic [7:0]           drop_cnt,
  output logic                 busy
);

  seq_state_t          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LABEL_W-1:0]  label_q;
  logic [PIX_W-1:0]    pixels_q;
  logic [LABEL_W-1:0]  pred_q;
  logic [7:0]          tx_data_q;
  logic [15:0]         frame_cnt_q, correct_cnt_q;
  logic [7:0]          drop_cnt_q;
  logic [LABEL_W-1:0]  best_idx;
  logic                l2_done;

  assign l2_done = (state_q == S_L2_WAIT) && bus.eng_done;

  argmax_tracker #(.SCORE_W(SCORE_W)) u_argmax (
    .clk      (clk),
    .reset_b  (reset_b),
    .init     (l2_done && (idx_q == '0)),
    .update   (l2_done && (idx_q != '0)),
    .score    (bus.eng_score),
    .index    (idx_q[LABEL_W-1:0]),
    .best_idx (best_idx)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    bus.eng_start = 1'b0;
    bus.tx_start  = 1'b0;
    pred_valid    = 1'b0;
    case (state_q)
      S_IDLE: if (frame_valid) begin
        idx_d   = '0;
        state_d = S_L1_ISSUE;
      end
      S_L1_ISSUE: begin
        bus.eng_start = 1'b1;
        state_d       = S_L1_WAIT;
      end
      S_L1_WAIT: if (bus.eng_done) begin
        if (idx_q == IDX_W'(N_HIDDEN - 1)) begin
          idx_d   = '0;
          state_d = S_L2_ISSUE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_L1_ISSUE;
        end
      end
      S_L2_ISSUE: begin
        bus.eng_start = 1'b1;
        state_d       = S_L2_WAIT;
      end
      S_L2_WAIT: if (bus.eng_done) begin
        if (idx_q == IDX_W'(N_OUT - 1)) begin
          state_d = S_REPORT;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_L2_ISSUE;
        end
      end
      S_REPORT: begin
        pred_valid = 1'b1;
        if (!bus.tx_busy) begin
          bus.tx_start = 1'b1;
          state_d      = S_IDLE;
        end else begin
          state_d = S_TX_WAIT;
        end
      end
      S_TX_WAIT: if (!bus.tx_busy) begin
        bus.tx_start = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      label_q       <= '0;
      pixels_q      <= '0;
      pred_q        <= '0;
      tx_data_q     <= '0;
      frame_cnt_q   <= '0;
      correct_cnt_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == S_IDLE && frame_valid) begin
        label_q  <= frame_label;
        pixels_q <= frame_pixels;
      end
      if (state_q != S_IDLE && frame_valid && drop_cnt_q != 8'hFF)
        drop_cnt_q <= drop_cnt_q + 8'd1;
      // Counters become visible the cycle after pred_valid.
      if (state_q == S_REPORT) begin
        pred_q      <= best_idx;
        tx_data_q   <= ASCII_ZERO + 8'(best_idx);
        frame_cnt_q <= frame_cnt_q + 16'd1;
        if (best_idx == label_q)
          correct_cnt_q <= correct_cnt_q + 16'd1;
      end
    end
  end

  // REPORT presents the fresh argmax directly; later cycles hold the registered copy.
  assign pred_out       = (state_q == S_REPORT) ? best_idx : pred_q;
  assign bus.tx_data    = (state_q == S_REPORT) ? (ASCII_ZERO + 8'(best_idx)) : tx_data_q;
  assign bus.eng_layer  = (state_q == S_L2_ISSUE) || (state_q == S_L2_WAIT);
  assign bus.eng_index  = idx_q;
  assign bus.eng_pixels = pixels_q;
  assign busy           = (state_q != S_IDLE);
  assign frame_cnt      = frame_cnt_q;
  assign correct_cnt    = correct_cnt_q;
  assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_inference_sequencer.sv
// Self-checking bench: table vectors, randomized frames against a reference
// model, plus hand sequences for counter saturation and mid-inference reset.
module tb_inference_sequencer;

  localparam int NH = 32;
  localparam int NO = 10;

  logic         clk;
  logic         reset_b;
  logic         frame_valid;
  logic [3:0]   frame_label;
  logic [783:0] frame_pixels;
  logic         pred_valid;
  logic [3:0]   pred_out;
  logic [15:0]  frame_cnt;
  logic [15:0]  correct_cnt;
  logic [7:0]   drop_cnt;
  logic         busy;

  inference_sequencer_if #(.PIX_W(784), .SCORE_W(16)) bus ();

  inference_sequencer #(.N_HIDDEN(NH), .N_OUT(NO), .SCORE_W(16), .PIX_W(784)) dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .frame_valid  (frame_valid),
    .frame_label  (frame_label),
    .frame_pixels (frame_pixels),
    .bus          (bus),
    .pred_valid   (pred_valid),
    .pred_out     (pred_out),
    .frame_cnt    (frame_cnt),
    .correct_cnt  (correct_cnt),
    .drop_cnt     (drop_cnt),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic signed [15:0] out_scores [NO];
  int eng_d = 3;
  int m_frames = 0, m_correct = 0, m_drops = 0;

  typedef struct {
    int         kind;
    int         peak;
    logic [3:0] label;
    int         d;
    int         busy_cyc;
    int         drops;
    bit         exit_drop;
    logic [3:0] exp_pred;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Engine model: eng_done exactly eng_d cycles after each eng_start.
  initial begin
    int cnt;
    cnt = 0;
    bus.eng_done  = 1'b0;
    bus.eng_score = '0;
    forever begin
      @(posedge clk); #1;
      bus.eng_done = 1'b0;
      if (!reset_b) begin
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.eng_done = 1'b1;
          if (bus.eng_layer && bus.eng_index < 6'(NO))
            bus.eng_score = out_scores[bus.eng_index];
          else
            bus.eng_score = 16'($urandom);
        end
      end else if (bus.eng_start) begin
        cnt = eng_d;
      end
    end
  end

  function automatic logic [783:0] rand_pixels();
    logic [783:0] p;
    for (int i = 0; i < 25; i++) p[i*32 +: 16] = 16'($urandom);
    for (int i = 0; i < 784; i += 7) p[i] = 1'($urandom);
    return p;
  endfunction

  // Highest score wins; among equal maxima the lowest index.
  function automatic logic [3:0] ref_argmax();
    int m;
    m = out_scores[0];
    for (int i = 1; i < NO; i++) if (int'(out_scores[i]) > m) m = out_scores[i];
    for (int i = 0; i < NO; i++) if (int'(out_scores[i]) == m) return 4'(i);
    return 4'd0;
  endfunction

  function automatic void fill_scores(input int kind, input int peak);
    for (int i = 0; i < NO; i++) begin
      case (kind)
        0: out_scores[i] = (i == peak) ? 16'sd1000 : 16'(i * 10 - 40);
        1: out_scores[i] = (i == 2 || i == 5) ? 16'sh0100 : 16'(i);
        default: out_scores[i] = 16'(i - 10);
      endcase
    end
  endfunction

  task automatic check_all_zero(input string nm);
    chk({nm, "_pred_valid"}, 32'(pred_valid), 0);
    chk({nm, "_pred_out"}, 32'(pred_out), 0);
    chk({nm, "_frame_cnt"}, 32'(frame_cnt), 0);
    chk({nm, "_correct_cnt"}, 32'(correct_cnt), 0);
    chk({nm, "_drop_cnt"}, 32'(drop_cnt), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_eng_start"}, 32'(bus.eng_start), 0);
    chk({nm, "_eng_layer"}, 32'(bus.eng_layer), 0);
    chk({nm, "_eng_index"}, 32'(bus.eng_index), 0);
    chk({nm, "_tx_start"}, 32'(bus.tx_start), 0);
    chk({nm, "_tx_data"}, 32'(bus.tx_data), 0);
    chk({nm, "_eng_pixels_zero"}, 32'(bus.eng_pixels != '0), 0);
  endtask

  // Runs one frame starting now (cycle 0); scores must already be in out_scores.
  task automatic run_frame(input vec_t v, input string nm);
    int pred_cyc, tx_cyc, n_tx, busy_left, exp_cyc, n_drop;
    logic [783:0] pix;
    logic [7:0] exp_tx;
    pix       = rand_pixels();
    eng_d     = v.d;
    exp_tx    = 8'h30 + 8'(v.exp_pred);
    exp_cyc   = 1 + (NH + NO) * (v.d + 1);
    pred_cyc  = -1;
    tx_cyc    = -1;
    n_tx      = 0;
    n_drop    = 0;
    busy_left = v.busy_cyc;
    frame_valid  = 1'b1;
    frame_label  = v.label;
    frame_pixels = pix;
    bus.tx_busy  = 1'b0;
    for (int cyc = 1; cyc <= exp_cyc + v.busy_cyc + 3; cyc++) begin
      @(posedge clk); #2;
      frame_valid = (cyc >= 2) && (cyc < 2 + v.drops);
      if (frame_valid) begin
        frame_label  = 4'($urandom_range(0, 15));
        frame_pixels = ~pix;
        n_drop++;
      end
      if (pred_valid) pred_cyc = cyc;
      if (pred_cyc >= 0 && tx_cyc < 0) begin
        bus.tx_busy = (busy_left > 0);
        busy_left--;
      end else begin
        bus.tx_busy = 1'b0;
      end
      #1;
      if (pred_valid) begin
        chk({nm, "_pred_out"}, 32'(pred_out), 32'(v.exp_pred));
        chk({nm, "_eng_pixels"}, 32'(bus.eng_pixels == pix), 1);
      end
      if (pred_cyc >= 0 && tx_cyc < 0)
        chk({nm, "_tx_data"}, 32'(bus.tx_data), 32'(exp_tx));
      if (tx_cyc >= 0 && cyc == tx_cyc + 1)
        chk({nm, "_busy_fall"}, 32'(busy), 0);
      if (bus.tx_start) begin
        n_tx++;
        tx_cyc = cyc;
        if (v.exit_drop) begin
          frame_valid = 1'b1;
          frame_label = v.label;
          n_drop++;
        end
      end
    end
    @(posedge clk); #2;
    frame_valid = 1'b0;
    bus.tx_busy = 1'b0;
    #1;
    chk({nm, "_pred_cycle"}, 32'(pred_cyc), 32'(exp_cyc));
    chk({nm, "_tx_count"}, 32'(n_tx), 1);
    chk({nm, "_tx_cycle"}, 32'(tx_cyc), 32'(pred_cyc + v.busy_cyc));
    m_frames++;
    if (v.exp_pred == v.label) m_correct++;
    m_drops = (m_drops + n_drop > 255) ? 255 : m_drops + n_drop;
    chk({nm, "_frame_cnt"}, 32'(frame_cnt), 32'(m_frames & 16'hFFFF));
    chk({nm, "_correct_cnt"}, 32'(correct_cnt), 32'(m_correct & 16'hFFFF));
    chk({nm, "_drop_cnt"}, 32'(drop_cnt), 32'(m_drops));
    chk({nm, "_idle"}, 32'(busy), 0);
    $display("frame %s: label=%0d pred=%0d tx=%0h pred_cyc=%0d frames=%0d correct=%0d drops=%0d",
             nm, v.label, pred_out, bus.tx_data, pred_cyc, frame_cnt, correct_cnt, drop_cnt);
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{0, 7, 4'd7, 3, 0,  0, 1'b0, 4'd7};  // nominal
    tbl[1] = '{1, 0, 4'd2, 1, 0,  0, 1'b0, 4'd2};  // tie keeps lowest index
    tbl[2] = '{2, 0, 4'd4, 2, 0,  0, 1'b0, 4'd9};  // all negative, wrong label
    tbl[3] = '{0, 3, 4'd3, 2, 20, 0, 1'b0, 4'd3};  // transmitter busy 20 cycles
    tbl[4] = '{0, 0, 4'd0, 3, 0,  3, 1'b0, 4'd0};  // three drops in L1_WAIT
    tbl[5] = '{0, 9, 4'd5, 1, 2,  0, 1'b1, 4'd9};  // drop on the return-to-idle cycle

    reset_b      = 1'b0;
    frame_valid  = 1'b0;
    frame_label  = '0;
    frame_pixels = '0;
    bus.tx_busy  = 1'b0;
    fill_scores(0, 0);
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    reset_b = 1'b1;
    @(posedge clk); #2;

    for (int i = 0; i < 6; i++) begin
      fill_scores(tbl[i].kind, tbl[i].peak);
      run_frame(tbl[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < NO; k++)
        out_scores[k] = (i % 2 == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 15)) - 8);
      v.kind      = 0;
      v.peak      = 0;
      v.label     = 4'($urandom_range(0, 9));
      v.d         = int'($urandom_range(1, 4));
      v.busy_cyc  = int'($urandom_range(0, 5));
      v.drops     = int'($urandom_range(0, 2));
      v.exit_drop = 1'($urandom);
      v.exp_pred  = ref_argmax();
      run_frame(v, $sformatf("rand%0d", i));
    end

    // 300 drops during one long inference saturate drop_cnt.
    fill_scores(0, 4);
    v = '{0, 4, 4'd4, 10, 0, 300, 1'b0, 4'd4};
    run_frame(v, "saturate");
    chk("saturate_drop_255", 32'(drop_cnt), 255);

    // Reset during L2_WAIT, then a clean frame with counters from zero.
    fill_scores(0, 6);
    eng_d        = 3;
    frame_valid  = 1'b1;
    frame_label  = 4'd6;
    frame_pixels = rand_pixels();
    @(posedge clk); #2;
    frame_valid = 1'b0;
    repeat (130) @(posedge clk);
    #2;
    chk("midreset_in_l2", 32'(bus.eng_layer), 1);
    chk("midreset_busy_before", 32'(busy), 1);
    reset_b = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #2;
    check_all_zero("midreset_held");
    reset_b = 1'b1;
    m_frames  = 0;
    m_correct = 0;
    m_drops   = 0;
    @(posedge clk); #2;
    fill_scores(0, 7);
    run_frame(tbl[0], "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inference_sequencer.md
# inference_sequencer

Controls one MNIST inference after the frame buffer finishes a frame. It latches the label and pixel vector, then runs the shared neuron engine one neuron at a time: every hidden neuron first, then every output neuron. It tracks the argmax of the output scores, reports the prediction with running accuracy counters, and sends the predicted digit as ASCII to the UART transmitter. It sits between the frame buffer, the neuron engine and the UART transmitter.

## Interface
- N_HIDDEN, 32, hidden-layer neuron count (range 1..64)
- N_OUT, 10, output-layer neuron count (range 2..16)
- SCORE_W, 16, signed engine score width
- PIX_W, 784, pixel vector width
- clk  in  1  clock
- reset_b  in  1  asynchronous, active-low reset
- frame_valid  in  1  one-cycle pulse from frame buffer: frame ready
- frame_label  in  4  true digit, valid with frame_valid
- frame_pixels  in  PIX_W  pixel vector, valid with frame_valid
- eng_start  out  1  one-cycle pulse: compute neuron eng_layer/eng_index
- eng_layer  out  1  0 = hidden, 1 = output
- eng_index  out  6  neuron index within layer
- eng_pixels  out  PIX_W  latched frame pixels, stable throughout inference
- eng_done  in  1  one-cycle pulse: eng_score valid
- eng_score  in  SCORE_W  signed neuron result
- tx_start  out  1  one-cycle pulse to UART transmitter
- tx_data  out  8  ASCII digit, 8'h30 + prediction
- tx_busy  in  1  transmitter busy
- pred_valid  out  1  one-cycle pulse: pred_out and counters updated
- pred_out  out  4  predicted digit
- frame_cnt  out  16  frames completed, wraps
- correct_cnt  out  16  frames with pred_out == label, wraps
- drop_cnt  out  8  frames rejected while busy, saturates at 255
- busy  out  1  high in every state except IDLE

## Operation
- **Reset values:** all outputs 0, state IDLE, latches cleared.
- **States:** IDLE, L1_ISSUE, L1_WAIT, L2_ISSUE, L2_WAIT, REPORT, TX_WAIT.
- **IDLE:** on frame_valid, latch label and pixels, set index to 0, go to L1_ISSUE.
- **L1_ISSUE / L2_ISSUE:** eng_start=1 for this single cycle, then go to the matching WAIT state.
  - eng_layer and eng_index are held constant from ISSUE until eng_done.
- **L1_WAIT:** on eng_done:
  - if index == N_HIDDEN-1, clear index and go to L2_ISSUE;
  - otherwise increment index and go to L1_ISSUE.
- **L2_WAIT:** on eng_done, update argmax, then:
  - if index == N_OUT-1, go to REPORT;
  - otherwise increment index and go to L2_ISSUE.
- **Argmax rules:**
  - Signed compare.
  - Output neuron 0 initialises the best score.
  - A later neuron replaces the best only if strictly greater, so ties keep the lowest index.
- **REPORT (single cycle):**
  - pred_valid=1 and pred_out=argmax.
  - frame_cnt increments.
  - correct_cnt increments if argmax == latched label.
  - tx_data is loaded.
  - If tx_busy=0, tx_start=1 this cycle and go to IDLE; otherwise go to TX_WAIT.
- **TX_WAIT:** on the first cycle with tx_busy=0, tx_start=1 and go to IDLE. tx_data is held.
- **Engine protocol:**
  - eng_done is ignored outside the WAIT states.
  - eng_score is sampled only on the eng_done cycle.
  - Hidden-layer scores are not used by this block.
- **frame_valid while busy=1:** frame discarded, drop_cnt increments (saturating), latched data untouched.
- **frame_valid on the cycle that returns to IDLE:** dropped, because busy is still 1 that cycle.
- **Reset mid-inference:** immediate return to IDLE with all outputs 0. The engine shares reset_b.

## Timing
- frame_valid at cycle 0: eng_start for hidden neuron 0 is at cycle 1.
- With engine latency D (eng_done D≥1 cycles after eng_start), each neuron takes D+1 cycles.
- pred_valid occurs at cycle 1 + (N_HIDDEN+N_OUT)(D+1).
- tx_start occurs in the same cycle as pred_valid when tx_busy=0.
- busy falls the cycle after tx_start.
- The next frame can be accepted one cycle after that.

## Structure
- **Shared package mnist_pkg:**
  - state enum;
  - ASCII_ZERO = 8'h30;
  - LABEL_W = 4;
  - PIX_W default;
  - the index width.
- **Sub-module argmax_tracker:** holds the best score and index, with ports init, update, score, index, best_idx.

## Test plan
- **Nominal run:** defaults, D=3, label 7, engine makes output 7 largest → pred_valid at cycle 169, pred_out=7, tx_data=8'h37, correct_cnt=1, frame_cnt=1.
- **Tie:** outputs 2 and 5 both score 16'sh0100, all others lower → pred_out=2.
- **All negative:** outputs -10..-1 with neuron 9 = -1 → pred_out=9; label 4 → correct_cnt unchanged, frame_cnt increments.
- **Transmitter busy:** tx_busy high for 20 cycles after REPORT → tx_start exactly once, on the first cycle tx_busy=0; tx_data stable throughout.
- **Overlapping frames:** frame_valid during L1_WAIT ×3 → drop_cnt=3, original inference result unaffected; after 300 dropped frames drop_cnt=255.
- **Reset mid-inference:** reset_b low during L2_WAIT → all outputs 0, busy=0; the next frame runs normally with counters starting from 0.
